mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter RAM_AW, default 10, giving the RAM word-address width (2^RAM_AW 32-bit words).
REQ-002 The block SHALL have port clk, input, 1, the clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; asynchronous, active-low.
REQ-004 The block SHALL have port req_valid, input, 1, core load/store request.
REQ-005 The block SHALL have port req_ready, output, 1, request accepted when high together with req_valid.
REQ-006 The block SHALL have port req_write, input, 1, 1=store, 0=load.
REQ-007 The block SHALL have port req_size, input, 2, 00=byte, 01=half, 10=word, 11=illegal.
REQ-008 The block SHALL have port req_unsigned, input, 1, zero-extend loads when 1, sign-extend when 0.
REQ-009 The block SHALL have port req_addr, input, 32, byte address.
REQ-010 The block SHALL have port req_wdata, input, 32, store data, right-justified.
REQ-011 The block SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-012 The block SHALL have port resp_error, output, 1, valid with resp_valid; access faulted.
REQ-013 The block SHALL have port resp_rdata, output, 32, extended load data; valid with resp_valid.
REQ-014 The block SHALL have port ram_en, output, 1, RAM access strobe.
REQ-015 The block SHALL have port ram_we, output, 1, RAM write strobe.
REQ-016 The block SHALL have port ram_be, output, 4, byte enables; bit k enables bits [8k+7:8k].
REQ-017 The block SHALL have port ram_addr, output, RAM_AW, word address = req_addr[RAM_AW+1:2].
REQ-018 The block SHALL have ports ram_wdata, output, 32, lane-positioned write data, and ram_rdata, input, 32, RAM read data, valid in the cycle after an ram_en cycle.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP and FAULT; req_ready SHALL be 1 only in IDLE.
REQ-020 In IDLE with req_valid, the block SHALL latch all req_* fields and go to FAULT if faulted, else to ISSUE.
REQ-021 A request SHALL fault when any of these hold: req_size=11; half with req_addr[0]=1; word with req_addr[1:0]!=00; req_addr[31:RAM_AW+2] nonzero.
REQ-022 ISSUE SHALL drive ram_en=1 and ram_we=latched write for exactly one cycle, then go to WAIT; in all other states ram_en, ram_we and ram_be SHALL be 0.
REQ-023 ram_be SHALL be 0001<<addr[1:0] for byte, 0011<<addr[1] * 2 for half, and 1111 for word; ram_be SHALL be driven for loads as well as stores.
REQ-024 ram_wdata SHALL hold the byte replicated to all four lanes for byte stores, the half replicated to both halves for half stores, and the full word for word stores.
REQ-025 In WAIT, the block SHALL shift the selected lane of ram_rdata down to bit 0, extend it per req_unsigned/req_size into resp_rdata, and go to RESP.
REQ-026 resp_rdata SHALL be 0 for stores and faults.
REQ-027 RESP SHALL assert resp_valid=1 and resp_error=0 for exactly one cycle, then go to IDLE.
REQ-028 FAULT SHALL assert resp_valid=1 and resp_error=1 for one cycle with no RAM access, then go to IDLE.
REQ-029 Latency SHALL be accept edge to resp_valid 3 cycles for a legal access and 1 cycle for a fault; a new request SHALL be acceptable in the cycle after resp_valid.
REQ-030 req_* changes after acceptance SHALL have no effect on the in-flight access.

Reset
REQ-031 When rst is low, the block SHALL enter IDLE immediately and zero resp_valid, resp_error, resp_rdata, ram_en, ram_we, ram_be and all latched request fields.
REQ-032 A reset asserted mid-access SHALL abort that access with no response; a write SHALL not be issued unless ISSUE already completed before reset.

Verification
REQ-033 Word store addr 0x10, data 0xDEADBEEF, then word load 0x10 -> store: ram_be=1111, ram_addr=4; load: resp_rdata=0xDEADBEEF, resp_valid 3 cycles after accept.
REQ-034 Byte load signed addr 0x13 with RAM word 0x80FF1234 -> ram_be=1000, resp_rdata=0xFFFFFF80; the same load unsigned -> 0x00000080.
REQ-035 Half store 0xABCD to 0x06 -> ram_be=1100, ram_wdata=0xABCDABCD; then half load signed from 0x06 -> 0xFFFFABCD.
REQ-036 Faults: word at 0x02, half at 0x01, size 11, and addr 0x00001000 (RAM_AW=10) -> each gives resp_valid and resp_error 1 cycle after accept, with ram_en never high.
REQ-037 Back-to-back: req_valid held high for two requests -> second is accepted in the cycle after the first resp_valid, and req_ready is 0 during ISSUE, WAIT and RESP.
REQ-038 rst pulsed low during WAIT of a load -> all outputs are 0 immediately, no resp_valid follows, and req_ready is 1 on the first cycle after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between a core request port and a single-port synchronous RAM.
// Handles byte/half/word lanes, alignment and range faults, and load extension.
module mem_access_unit #(
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_error,
    output logic [31:0]       resp_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Only the in-range address bits are kept; anything above them faults at accept.
    logic                r_write;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [RAM_AW+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;

    logic                w_accept;
    logic                w_misalign;
    logic                w_out_of_range;
    logic                w_fault;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic [7:0]          w_lane_byte;
    logic [15:0]         w_lane_half;
    logic [31:0]         w_load_ext;

    assign w_accept = (r_state == IDLE) && req_valid;

    assign w_misalign = (req_size == SZ_ILL)
                      || ((req_size == SZ_HALF) && req_addr[0])
                      || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign w_out_of_range = |req_addr[31:RAM_AW+2];
    assign w_fault        = w_misalign || w_out_of_range;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_next = w_fault ? FAULT : ISSUE;
                end
            end
            ISSUE:   w_state_next = WAIT;
            WAIT:    w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            FAULT:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_write    <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
        end else if (w_accept) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr[RAM_AW+1:0];
            r_wdata    <= req_wdata;
            r_rdata    <= 32'h0;
        end else if (r_state == WAIT) begin
            r_rdata    <= r_write ? 32'h0 : w_load_ext;
        end
    end

    // Per-lane enables and write data; the narrow store value is replicated
    // so the RAM only needs the byte enables to pick the destination.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign w_be[gi] = (r_size == SZ_WORD)
                           || ((r_size == SZ_HALF) && (r_addr[1] == LANE[1]))
                           || ((r_size == SZ_BYTE) && (r_addr[1:0] == LANE));
            assign w_wdata[8*gi +: 8] = (r_size == SZ_BYTE) ? r_wdata[7:0]
                                      : (r_size == SZ_HALF) ? r_wdata[8*(gi%2) +: 8]
                                      : r_wdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        w_lane_byte = ram_rdata[7:0];
        case (r_addr[1:0])
            2'b00:   w_lane_byte = ram_rdata[7:0];
            2'b01:   w_lane_byte = ram_rdata[15:8];
            2'b10:   w_lane_byte = ram_rdata[23:16];
            default: w_lane_byte = ram_rdata[31:24];
        endcase
    end

    assign w_lane_half = r_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    always_comb begin
        w_load_ext = ram_rdata;
        case (r_size)
            SZ_BYTE: w_load_ext = {{24{~r_unsigned & w_lane_byte[7]}}, w_lane_byte};
            SZ_HALF: w_load_ext = {{16{~r_unsigned & w_lane_half[15]}}, w_lane_half};
            default: w_load_ext = ram_rdata;
        endcase
    end

    // Ready is also masked by reset so every output reads 0 while rst is low.
    assign req_ready  = (r_state == IDLE) && rst;
    assign ram_en     = (r_state == ISSUE);
    assign ram_we     = (r_state == ISSUE) && r_write;
    assign ram_be     = (r_state == ISSUE) ? w_be : 4'b0000;
    assign ram_addr   = r_addr[RAM_AW+1:2];
    assign ram_wdata  = w_wdata;
    assign resp_valid = (r_state == RESP) || (r_state == FAULT);
    assign resp_error = (r_state == FAULT);
    assign resp_rdata = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 1-cycle-latency RAM.
// Expected values are hand-computed per transaction.
module tb_mem_access_unit;

    localparam int RAM_AW = 10;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_error;
    logic [31:0]       resp_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    mem_access_unit #(.RAM_AW(RAM_AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_error   (resp_error),
        .resp_rdata   (resp_rdata),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_be       (ram_be),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM; the poke port lets the bench preload words.
    logic [31:0]       mem [0:(1<<RAM_AW)-1];
    logic              pl_en;
    logic [RAM_AW-1:0] pl_idx;
    logic [31:0]       pl_val;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int k = 0; k < 4; k++) begin
                    if (ram_be[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
                end
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    int n_checks;
    int n_errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    int          t_lat;
    int          t_en;
    bit          t_rv;
    bit          t_busy;
    logic        t_err;
    logic        t_we;
    logic [31:0] t_rdata;
    logic [3:0]  t_be;
    logic [31:0] t_wdata;
    logic [31:0] t_addr;

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = RAM_AW'(idx);
        pl_val = val;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    // Issue one request, scramble req_* after acceptance, and record what happens.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        chk("ready_idle", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_write    = ~w;
        req_size     = ~sz;
        req_unsigned = ~u;
        req_addr     = ~a;
        req_wdata    = ~d;
        t_lat = 0; t_en = 0; t_rv = 0; t_busy = 0;
        t_err = 1'b0; t_we = 1'b0; t_rdata = 32'h0; t_be = 4'h0; t_wdata = 32'h0; t_addr = 32'h0;
        for (int c = 1; c <= 8 && !t_rv; c++) begin
            @(negedge clk);
            if (req_ready) t_busy = 1;
            if (ram_en) begin
                t_en++;
                t_be    = ram_be;
                t_we    = ram_we;
                t_wdata = ram_wdata;
                t_addr  = 32'(ram_addr);
            end
            if (resp_valid) begin
                t_rv    = 1;
                t_lat   = c;
                t_err   = resp_error;
                t_rdata = resp_rdata;
            end
        end
        $display("TXN w=%0d sz=%0d u=%0d addr=%08h wdata=%08h -> lat=%0d err=%0d rdata=%08h be=%04b ram_wdata=%08h",
                 w, sz, u, a, d, t_lat, t_err, t_rdata, t_be, t_wdata);
    endtask

    task automatic expect_ok(input string tag, input logic w, input logic [31:0] rdata,
                             input logic [3:0] be, input logic [31:0] addr);
        chk({tag, "_lat"},   32'(t_lat), 32'd3);
        chk({tag, "_err"},   {31'b0, t_err}, 32'd0);
        chk({tag, "_en"},    32'(t_en), 32'd1);
        chk({tag, "_we"},    {31'b0, t_we}, {31'b0, w});
        chk({tag, "_be"},    {28'b0, t_be}, {28'b0, be});
        chk({tag, "_addr"},  t_addr, addr);
        chk({tag, "_rdata"}, t_rdata, rdata);
        chk({tag, "_busy"},  {31'b0, t_busy}, 32'd0);
    endtask

    task automatic expect_fault(input string tag);
        chk({tag, "_lat"},   32'(t_lat), 32'd1);
        chk({tag, "_err"},   {31'b0, t_err}, 32'd1);
        chk({tag, "_en"},    32'(t_en), 32'd0);
        chk({tag, "_rdata"}, t_rdata, 32'h0);
    endtask

    bit exp_rdy [1:7];
    bit exp_rv  [1:7];
    int rv_seen;

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        pl_en = 1'b0; pl_idx = '0; pl_val = 32'h0;

        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_ram_en", {31'b0, ram_en}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_rv", {31'b0, resp_valid}, 32'd0);
        chk("post_rst_be", {28'b0, ram_be}, 32'd0);
        chk("post_rst_rdata", resp_rdata, 32'h0);

        // Word store then load.
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        expect_ok("wst", 1'b1, 32'h0, 4'b1111, 32'd4);
        chk("wst_wdata", t_wdata, 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        expect_ok("wld", 1'b0, 32'hDEADBEEF, 4'b1111, 32'd4);

        // Byte loads from lane 3, signed and unsigned.
        poke(4, 32'h80FF1234);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        expect_ok("bld_s", 1'b0, 32'hFFFFFF80, 4'b1000, 32'd4);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        expect_ok("bld_u", 1'b0, 32'h00000080, 4'b1000, 32'd4);

        // Half store to upper half, then loads from it.
        poke(1, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 32'h06, 32'h9999ABCD);
        expect_ok("hst", 1'b1, 32'h0, 4'b1100, 32'd1);
        chk("hst_wdata", t_wdata, 32'hABCDABCD);
        do_req(1'b0, 2'b01, 1'b0, 32'h06, 32'h0);
        expect_ok("hld_s", 1'b0, 32'hFFFFABCD, 4'b1100, 32'd1);
        do_req(1'b0, 2'b00, 1'b1, 32'h07, 32'h0);
        expect_ok("bld7_u", 1'b0, 32'h000000AB, 4'b1000, 32'd1);

        // Byte store replication into lane 1.
        do_req(1'b1, 2'b00, 1'b0, 32'h01, 32'h1234565A);
        expect_ok("bst", 1'b1, 32'h0, 4'b0010, 32'd0);
        chk("bst_wdata", t_wdata, 32'h5A5A5A5A);

        // Highest legal word.
        do_req(1'b1, 2'b10, 1'b0, 32'hFFC, 32'h13579BDF);
        expect_ok("top_st", 1'b1, 32'h0, 4'b1111, 32'd1023);
        do_req(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
        expect_ok("top_ld", 1'b0, 32'h13579BDF, 4'b1111, 32'd1023);

        // Faults.
        do_req(1'b0, 2'b10, 1'b0, 32'h02, 32'h0);
        expect_fault("f_word");
        do_req(1'b1, 2'b01, 1'b0, 32'h01, 32'h0);
        expect_fault("f_half");
        do_req(1'b0, 2'b11, 1'b0, 32'h00, 32'h0);
        expect_fault("f_size");
        do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
        expect_fault("f_range");

        // Back-to-back: A = word load 0x10, B = unsigned half load 0x12.
        exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_rv  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
        chk("b2b_ready0", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_size = 2'b01; req_unsigned = 1'b1; req_addr = 32'h12;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready%0d", c), {31'b0, req_ready}, {31'b0, exp_rdy[c]});
            chk($sformatf("b2b_rv%0d", c), {31'b0, resp_valid}, {31'b0, exp_rv[c]});
            if (c == 3) chk("b2b_rdataA", resp_rdata, 32'h80FF1234);
            if (c == 7) chk("b2b_rdataB", resp_rdata, 32'h000080FF);
            if (c == 4) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
            end
        end
        $display("TXN back-to-back word 0x10 then half 0x12 done");

        // Reset during WAIT of a load aborts it.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rw_issue_en", {31'b0, ram_en}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rw_rv", {31'b0, resp_valid}, 32'd0);
        chk("rw_err", {31'b0, resp_error}, 32'd0);
        chk("rw_rdata", resp_rdata, 32'h0);
        chk("rw_en", {31'b0, ram_en}, 32'd0);
        chk("rw_we", {31'b0, ram_we}, 32'd0);
        chk("rw_be", {28'b0, ram_be}, 32'd0);
        chk("rw_addr", 32'(ram_addr), 32'd0);
        chk("rw_wdata", ram_wdata, 32'h0);
        chk("rw_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rw_ready_rel", {31'b0, req_ready}, 32'd1);
        rv_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) rv_seen++;
        end
        chk("rw_no_resp", 32'(rv_seen), 32'd0);
        $display("TXN reset during WAIT of word load 0x10 done");

        // Reset during ISSUE of a store: the write must not land.
        poke(5, 32'h0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h14; req_wdata = 32'h11111111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        $display("TXN reset during ISSUE of word store 0x14 done");
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        expect_ok("ri_ld", 1'b0, 32'h0, 4'b1111, 32'd5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
